tone_analyzer: RTL and testbench

Measurement-side counterpart of the ROM-based sine generator. Takes a signed audio sample stream qualified by `sample_tick_i` and finds rising zero crossings through a hysteresis comparator. For each full period it reports the period length in ticks and the peak magnitude as an 8-bit level. It also reports the equivalent generator phase step `RES/period`, so a measured tone can be re-synthesised or used to drive modulation. It sits on the input sample path, in parallel with the effect chain.

---
 rtl/tone_analyzer.sv | 198 +++++++++++++++++++
 tb/tb_tone_analyzer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_analyzer.sv
// tone_analyzer: hysteresis zero-crossing meter reporting period, peak level and phase step.
// Define TONE_ANALYZER_DIV_EN to build the sequential RES/period divider (else mult_o = 0).
module tone_analyzer #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned RES      = 256,
    parameter int unsigned HYST     = 256,
    parameter int unsigned PERIOD_W = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     sample_tick_i,
    input  logic signed [DWIDTH-1:0] data_i,
    output logic [PERIOD_W-1:0]      period_o,
    output logic [7:0]               level_o,
    output logic [$clog2(RES):0]     mult_o,
    output logic                     valid_o,
    output logic                     no_signal_o
);

    localparam logic signed [DWIDTH-1:0] HYST_POS = DWIDTH'(HYST);
    localparam logic signed [DWIDTH-1:0] HYST_NEG = -HYST_POS;
    localparam logic [DWIDTH-1:0]        MAG_MAX  = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [PERIOD_W-1:0]      CNT_MAX  = '1;

`ifdef TONE_ANALYZER_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DIV} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_MEASURE} state_t;
`endif

    state_t              state, state_nxt;
    logic                pol;
    logic [PERIOD_W-1:0] cnt, cnt_inc_c;
    logic [DWIDTH-1:0]   peak, mag_c;
    logic                pos_c, neg_c, rise_c, timeout_c;
    logic                restart_c, count_c, latch_c, to_idle_c;

`ifdef TONE_ANALYZER_DIV_EN
    localparam int unsigned QW = $clog2(RES) + 1;
    localparam int unsigned SW = $clog2(QW);

    logic [PERIOD_W-1:0] lat_period, rem;
    logic [7:0]          lat_level;
    logic [QW-1:0]       dvd, quo, quo_nxt_c;
    logic [SW-1:0]       step;
    logic [PERIOD_W:0]   trial_c;
    logic                qbit_c, div_last_c;
`endif

    // Hysteresis comparator, crossing detect and saturated magnitude
    always_comb begin
        pos_c     = sample_tick_i && (data_i >= HYST_POS);
        neg_c     = sample_tick_i && (data_i <= HYST_NEG);
        rise_c    = pos_c && !pol;
        cnt_inc_c = cnt + PERIOD_W'(1);
        timeout_c = sample_tick_i && !rise_c && (cnt_inc_c == CNT_MAX);
        if (data_i[DWIDTH-1])
            mag_c = (data_i[DWIDTH-2:0] == '0) ? MAG_MAX : DWIDTH'(-data_i);
        else
            mag_c = data_i;
    end

`ifdef TONE_ANALYZER_DIV_EN
    // Restoring divider step: one quotient bit of RES/period per clock
    always_comb begin
        trial_c    = {rem, dvd[QW-1]};
        qbit_c     = (trial_c >= {1'b0, lat_period});
        quo_nxt_c  = {quo[QW-2:0], qbit_c};
        div_last_c = (state == S_DIV) && (step == SW'(QW-1));
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (rise_c) state_nxt = S_MEASURE;
            S_MEASURE: begin
`ifdef TONE_ANALYZER_DIV_EN
                if (latch_c)        state_nxt = S_DIV;
                else if (to_idle_c) state_nxt = S_IDLE;
`else
                if (to_idle_c)      state_nxt = S_IDLE;
`endif
            end
`ifdef TONE_ANALYZER_DIV_EN
            S_DIV:     if (div_last_c) state_nxt = S_MEASURE;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Datapath strobes; a crossing during DIV restarts the count but is not latched
    always_comb begin
        restart_c = rise_c;
        count_c   = 1'b0;
        latch_c   = 1'b0;
        to_idle_c = 1'b0;
        case (state)
            S_MEASURE: begin
                count_c   = sample_tick_i && !rise_c;
                latch_c   = rise_c;
                to_idle_c = timeout_c;
            end
`ifdef TONE_ANALYZER_DIV_EN
            S_DIV:     count_c = sample_tick_i && !rise_c;
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pol  <= 1'b0;
            cnt  <= '0;
            peak <= '0;
        end else begin
            if (pos_c)      pol <= 1'b1;
            else if (neg_c) pol <= 1'b0;
            if (restart_c) begin
                cnt  <= PERIOD_W'(1);
                peak <= mag_c;
            end else if (count_c) begin
                cnt  <= cnt_inc_c;
                peak <= (mag_c > peak) ? mag_c : peak;
            end
        end
    end

`ifdef TONE_ANALYZER_DIV_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_period <= '0;
            lat_level  <= '0;
            rem        <= '0;
            dvd        <= '0;
            quo        <= '0;
            step       <= '0;
        end else if (latch_c) begin
            lat_period <= cnt;
            lat_level  <= peak[DWIDTH-2 -: 8];
            rem        <= '0;
            dvd        <= QW'(RES);
            step       <= '0;
        end else if (state == S_DIV) begin
            rem  <= qbit_c ? PERIOD_W'(trial_c - {1'b0, lat_period}) : trial_c[PERIOD_W-1:0];
            dvd  <= {dvd[QW-2:0], 1'b0};
            quo  <= quo_nxt_c;
            step <= step + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_o    <= '0;
            level_o     <= '0;
            mult_o      <= '0;
            valid_o     <= 1'b0;
            no_signal_o <= 1'b1;
        end else begin
            valid_o <= div_last_c;
            if (div_last_c) begin
                period_o    <= lat_period;
                level_o     <= lat_level;
                mult_o      <= quo_nxt_c;
                no_signal_o <= 1'b0;
            end else if (to_idle_c) begin
                no_signal_o <= 1'b1;
            end
        end
    end
`else
    assign mult_o = '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_o    <= '0;
            level_o     <= '0;
            valid_o     <= 1'b0;
            no_signal_o <= 1'b1;
        end else begin
            valid_o <= latch_c;
            if (latch_c) begin
                period_o    <= cnt;
                level_o     <= peak[DWIDTH-2 -: 8];
                no_signal_o <= 1'b0;
            end else if (to_idle_c) begin
                no_signal_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tone_analyzer.sv
// tb_tone_analyzer: directed sine / square / timeout / reset vectors with a queue scoreboard.
`timescale 1ns/1ps
module tb_tone_analyzer;

    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned RES      = 256;
    localparam int unsigned HYST     = 256;
    localparam int unsigned PERIOD_W = 12;
    localparam int unsigned MW       = $clog2(RES) + 1;
    localparam int          NEVER    = 1 << 30;
    localparam real         PI       = 3.14159265358979;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     tick;
    logic signed [DWIDTH-1:0] data;
    logic [PERIOD_W-1:0]      period;
    logic [7:0]               level;
    logic [MW-1:0]            mult;
    logic                     valid;
    logic                     no_signal;

    typedef struct {
        int period;
        int level;
        int mult;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tbl[256];

    tone_analyzer #(
        .DWIDTH(DWIDTH), .RES(RES), .HYST(HYST), .PERIOD_W(PERIOD_W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .sample_tick_i(tick),
        .data_i       (data),
        .period_o     (period),
        .level_o      (level),
        .mult_o       (mult),
        .valid_o      (valid),
        .no_signal_o  (no_signal)
    );

    always #5 clk = ~clk;

    function automatic int exp_mult(input int p);
`ifdef TONE_ANALYZER_DIV_EN
        return RES / p;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input int l);
        exp_t e;
        e.period = p;
        e.level  = l;
        e.mult   = exp_mult(p);
        sb_q.push_back(e);
    endtask

    // One sample tick, then idle so ticks are 8 clocks apart
    task automatic send(input int v);
        @(posedge clk);
        #1;
        data = DWIDTH'(v);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    function automatic int samp(input int phase, input int amp);
        case (amp)
            0:       return tbl[phase];
            1:       return tbl[phase] / 2;
            default: return (tbl[phase] * 200) / 32767;
        endcase
    endfunction

    // Crossing lands where k*step wraps to step, i.e. k mod period == 1
    task automatic run_sine(input int step, input int amp, input int k_first,
                            input int k_last, input int k_push_min, input int exp_lvl);
        int per;
        per = 256 / step;
        for (int k = k_first; k <= k_last; k++) begin
            if ((k % per) == 1 && k >= k_push_min) push(per, exp_lvl);
            send(samp((k * step) % 256, amp));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (20) @(posedge clk);
        #2;
        check(name, sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_mult"}, int'(mult), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_no_signal"}, int'(no_signal), 1);
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (sb_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_valid: got period=%0d level=%0d mult=%0d expected no pulse",
                         period, level, mult);
            end else begin
                e = sb_q.pop_front();
                check("sb_period", int'(period), e.period);
                check("sb_level", int'(level), e.level);
                check("sb_mult", int'(mult), e.mult);
                check("sb_no_signal", int'(no_signal), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        real r;
        for (int i = 0; i < 256; i++) begin
            r = 32767.0 * $sin(2.0 * PI * i / 256.0);
            tbl[i] = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
        end
        rst_n = 1'b0;
        tick  = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Below hysteresis: never locks
        run_sine(4, 2, 0, 199, NEVER, 0);
        drain("small_pending");
        check("small_no_signal", int'(no_signal), 1);
        check("small_period", int'(period), 0);
        check("small_level", int'(level), 0);
        check("small_mult", int'(mult), 0);

        // Full-scale sine, step 1
        do_reset();
        run_sine(1, 0, 0, 515, 257, 255);
        drain("full_pending");
        check("full_no_signal", int'(no_signal), 0);

        // Half-scale sine, step 4, then silence until timeout
        do_reset();
        run_sine(4, 1, 0, 193, 65, 127);
        for (int z = 1; z <= 4093; z++) send(0);
        check("half_pending", sb_q.size(), 0);
        check("pre_timeout_no_signal", int'(no_signal), 0);
        send(0);
        send(0);
        check("timeout_no_signal", int'(no_signal), 1);
        check("timeout_period", int'(period), 64);
        check("timeout_level", int'(level), 127);
        check("timeout_mult", int'(mult), exp_mult(64));

        // Minimum period: alternating +/-1000
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0 && k >= 2) push(2, 7);
            send(((k % 2) == 0) ? 1000 : -1000);
        end
        drain("alt_pending");

        // Reset mid-period, then resume the step-4 sine
        do_reset();
        run_sine(4, 1, 0, 100, 65, 127);
        drain("pre_rst_pending");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_sine(4, 1, 101, 200, 193, 127);
        drain("post_rst_pending");
        check("post_rst_period", int'(period), 64);
        check("post_rst_level", int'(level), 127);
        check("post_rst_no_signal", int'(no_signal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
